// File: rtl/wb_watchdog.sv
// wb_watchdog: Wishbone-programmable watchdog timer.
// Counts down from LOAD while enabled; a missed or wrong kick raises a
// fixed-length system reset request and parks the block in FIRE until
// wb_rst_i. Defining WB_WATCHDOG_PRETIMEOUT_EN adds a WARN stage that
// reloads once more and can raise irq_o before the final expiry.
module wb_watchdog #(
    parameter int unsigned RST_LEN  = 16,
    parameter logic [31:0] KICK_KEY = 32'h5A5A_5A5A
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        rst_req_o,
    output logic        irq_o
);

`ifdef WB_WATCHDOG_PRETIMEOUT_EN
    localparam logic PRE_EN = 1'b1;
`else
    localparam logic PRE_EN = 1'b0;
`endif

    localparam logic [7:0] RST_LEN_W = 8'(RST_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WARN = 2'd2,
        S_FIRE = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_load;
    logic [31:0] r_dat, w_rdata;
    logic        r_en, r_irq_en;
    logic        r_irq, w_irq_nxt;
    logic        r_ack, r_rst_req;
    logic [7:0]  r_fire_cnt;

    logic        w_acc, w_wr, w_wr_cfg;
    logic        w_wr_ctrl, w_wr_load, w_wr_kick, w_kick_ok;
    logic [1:0]  w_sel;
    logic        w_unused;

    // Byte lanes and the low address bits carry no meaning here.
    assign w_unused  = &{1'b0, wb_sel_i, wb_adr_i[1:0]};

    // An access is taken once per cyc&stb, on the edge where ack is still low.
    assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr      = w_acc & wb_we_i;
    assign w_sel     = wb_adr_i[3:2];
    // Once FIRE is reached software can no longer touch the configuration.
    assign w_wr_cfg  = w_wr & (r_state != S_FIRE);
    assign w_wr_ctrl = w_wr_cfg & (w_sel == 2'd0);
    assign w_wr_load = w_wr_cfg & (w_sel == 2'd1);
    assign w_wr_kick = w_wr_cfg & (w_sel == 2'd2);
    assign w_kick_ok = (wb_dat_i == KICK_KEY);

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 32'd0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // Next state, counter and irq; a kick outranks expiry on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_irq_nxt   = r_irq;
        case (r_state)
            S_IDLE: begin
                if (w_wr_ctrl && wb_dat_i[0]) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = r_load;
                end
            end
            S_RUN, S_WARN: begin
                if (w_wr_ctrl && !wb_dat_i[0]) begin
                    w_state_nxt = S_IDLE;
                    w_irq_nxt   = 1'b0;
                end else if (w_wr_kick) begin
                    if (w_kick_ok) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = r_load;
                        w_irq_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_FIRE;
                    end
                end else if (r_cnt == 32'd0) begin
                    if (PRE_EN && (r_state == S_RUN)) begin
                        w_state_nxt = S_WARN;
                        w_cnt_nxt   = r_load;
                        w_irq_nxt   = r_irq_en;
                    end else begin
                        w_state_nxt = S_FIRE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Software-visible configuration registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_load   <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= wb_dat_i[0];
                r_irq_en <= wb_dat_i[1];
            end
            if (w_wr_load) begin
                r_load <= wb_dat_i;
            end
        end
    end

    // Read mux; KICK is write-only and reads as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            2'd0:    w_rdata = {30'd0, PRE_EN & r_irq_en, r_en};
            2'd1:    w_rdata = r_load;
            2'd2:    w_rdata = 32'd0;
            default: w_rdata = {r_state, r_cnt[29:0]};
        endcase
    end

    // Bus handshake: single-cycle ack with read data registered alongside it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wb_we_i) ? w_rdata : 32'd0;
        end
    end

    // Reset request: RST_LEN cycles starting one cycle after FIRE entry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fire_cnt <= 8'd0;
            r_rst_req  <= 1'b0;
        end else if (r_state == S_FIRE) begin
            if (r_fire_cnt < RST_LEN_W) begin
                r_fire_cnt <= r_fire_cnt + 8'd1;
                r_rst_req  <= 1'b1;
            end else begin
                r_rst_req  <= 1'b0;
            end
        end else begin
            r_fire_cnt <= 8'd0;
            r_rst_req  <= 1'b0;
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat;
    assign rst_req_o = r_rst_req;

`ifdef WB_WATCHDOG_PRETIMEOUT_EN
    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_watchdog.sv
// tb_wb_watchdog: register table, directed watchdog sequences and a
// randomized phase checked every cycle against a behavioural model.
module tb_wb_watchdog;

`ifdef WB_WATCHDOG_PRETIMEOUT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif
    localparam int          RST_LEN = 16;
    localparam logic [31:0] KEY     = 32'h5A5A_5A5A;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, rst_req_o, irq_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    wb_watchdog #(.RST_LEN(RST_LEN), .KICK_KEY(KEY)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .rst_req_o(rst_req_o),
        .irq_o    (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_st: 0 idle, 1 run, 2 warn, 3 fire. m_age counts edges spent in fire;
    // the reset request is expected while 1 <= m_age <= RST_LEN.
    logic [1:0]  m_st;
    logic [31:0] m_cnt, m_load, m_dat, m_rd, m_oldload;
    bit          m_en, m_irqen, m_oldirqen, m_irq, m_ack, m_acc, m_wr;
    logic [1:0]  m_r;
    int          m_age;

    always @(posedge wb_clk_i) begin
        m_acc = wb_cyc_i && wb_stb_i && !m_ack;
        m_wr  = m_acc && wb_we_i;
        m_r   = wb_adr_i[3:2];
        if (wb_rst_i) begin
            m_st = 0; m_cnt = 0; m_load = 32'hFFFF_FFFF;
            m_en = 0; m_irqen = 0; m_irq = 0; m_ack = 0; m_dat = 0; m_age = 0;
        end else begin
            case (m_r)
                2'd0:    m_rd = {30'd0, PRE & m_irqen, m_en};
                2'd1:    m_rd = m_load;
                2'd2:    m_rd = 32'd0;
                default: m_rd = {m_st, m_cnt[29:0]};
            endcase
            m_dat = (m_acc && !wb_we_i) ? m_rd : 32'd0;
            m_ack = m_acc;
            if (m_st == 3) begin
                m_age++;
            end else begin
                m_oldload  = m_load;
                m_oldirqen = m_irqen;
                if (m_wr && m_r == 1) m_load = wb_dat_i;
                if (m_wr && m_r == 0) begin m_en = wb_dat_i[0]; m_irqen = wb_dat_i[1]; end
                if (m_st == 0) begin
                    if (m_wr && m_r == 0 && wb_dat_i[0]) begin m_st = 1; m_cnt = m_oldload; end
                end else if (m_wr && m_r == 0 && !wb_dat_i[0]) begin
                    m_st = 0; m_irq = 0;
                end else if (m_wr && m_r == 2) begin
                    if (wb_dat_i == KEY) begin m_st = 1; m_cnt = m_oldload; m_irq = 0; end
                    else begin m_st = 3; m_age = 0; end
                end else if (m_cnt == 0) begin
                    if (PRE && m_st == 1) begin m_st = 2; m_cnt = m_oldload; m_irq = m_oldirqen; end
                    else begin m_st = 3; m_age = 0; end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge wb_clk_i) begin
        if (chk_en) begin
            chk("ack",     {31'd0, wb_ack_o},  {31'd0, m_ack});
            chk("rst_req", {31'd0, rst_req_o},
                {31'd0, (m_st == 3 && m_age >= 1 && m_age <= RST_LEN)});
            chk("irq",     {31'd0, irq_o},     {31'd0, PRE & m_irq});
            chk("dat",     wb_dat_o,           m_dat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge wb_clk_i); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic xfer(input bit w, input logic [3:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        int n;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = w; wb_adr_i = a; wb_dat_i = d;
        wb_sel_i = 4'($urandom);
        n = 0;
        do begin step(); n++; end while (!wb_ack_o && n < 4);
        chk("xfer_ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1; idle(2); wb_rst_i = 0;
    endtask

    typedef struct {
        bit          we;
        logic [3:0]  adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    logic [31:0] rd;
    int k, h;

    initial begin
        tbl[0] = '{0, 4'h0, 32'h0,        32'h0};
        tbl[1] = '{0, 4'h4, 32'h0,        32'hFFFF_FFFF};
        tbl[2] = '{0, 4'hC, 32'h0,        32'h0};
        tbl[3] = '{1, 4'h4, 32'h0001_2345, 32'h0};
        tbl[4] = '{0, 4'h5, 32'h0,        32'h0001_2345};
        tbl[5] = '{1, 4'h0, 32'h2,        32'h0};
        tbl[6] = '{0, 4'h3, 32'h0,        PRE ? 32'h2 : 32'h0};
        tbl[7] = '{0, 4'h8, 32'h0,        32'h0};
        tbl[8] = '{1, 4'h8, KEY,          32'h0};
        tbl[9] = '{0, 4'hC, 32'h0,        32'h0};

        wb_rst_i = 1; wb_adr_i = 0; wb_dat_i = 0; wb_we_i = 0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_sel_i = 0;
        step();
        chk_en = 1;
        step();
        wb_rst_i = 0;

        // Register map table.
        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].we, tbl[i].adr, tbl[i].wd, rd);
            chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end

        // Unkicked expiry: latency to reset request, pulse width, FIRE status.
        do_reset();
        xfer(1, 4'h4, 32'd10, rd);
        xfer(1, 4'h0, 32'd1, rd);
        k = 0;
        while (!rst_req_o && k < 60) begin step(); k++; end
        chk("fire_lat", k, PRE ? 32'd23 : 32'd12);
        h = 0;
        while (rst_req_o && h < 300) begin step(); h++; end
        chk("pulse_len", h, RST_LEN);
        xfer(0, 4'hC, 32'h0, rd);
        chk("fire_status", {30'd0, rd[31:30]}, 32'd3);

        // Regular valid kicks keep the dog quiet.
        do_reset();
        xfer(1, 4'h4, 32'd10, rd);
        xfer(1, 4'h0, 32'd1, rd);
        for (int i = 0; i < 13; i++) begin
            idle(6);
            xfer(1, 4'h8, KEY, rd);
        end
        xfer(0, 4'hC, 32'h0, rd);
        chk("kick_state", {30'd0, rd[31:30]}, 32'd1);
        chk("kick_min_cnt", {31'd0, rd[29:0] >= 2}, 32'd1);

        // Wrong key fires immediately.
        xfer(1, 4'h8, 32'h1234_5678, rd);
        k = 0;
        while (!rst_req_o && k < 10) begin step(); k++; end
        chk("badkick_lat", k, 32'd1);
        h = 0;
        while (rst_req_o && h < 300) begin step(); h++; end
        chk("badkick_len", h, RST_LEN);

        // Reset in the middle of the pulse; a kick in IDLE then does nothing.
        do_reset();
        xfer(1, 4'h4, 32'd10, rd);
        xfer(1, 4'h0, 32'd1, rd);
        xfer(1, 4'h8, 32'hDEAD_BEEF, rd);
        idle(3);
        chk("mid_pulse", {31'd0, rst_req_o}, 32'd1);
        wb_rst_i = 1; step(); wb_rst_i = 0;
        chk("trunc_rst_req", {31'd0, rst_req_o}, 32'd0);
        xfer(0, 4'h4, 32'h0, rd);
        chk("load_after_rst", rd, 32'hFFFF_FFFF);
        xfer(0, 4'hC, 32'h0, rd);
        chk("status_after_rst", rd, 32'h0);
        xfer(1, 4'h8, KEY, rd);
        xfer(0, 4'hC, 32'h0, rd);
        chk("idle_kick", rd, 32'h0);

`ifdef WB_WATCHDOG_PRETIMEOUT_EN
        // Pre-timeout interrupt, recovery by kick, then second-stage expiry.
        do_reset();
        xfer(1, 4'h4, 32'd5, rd);
        xfer(1, 4'h0, 32'd3, rd);
        k = 0;
        while (!irq_o && k < 30) begin step(); k++; end
        chk("irq_lat", k, 32'd6);
        xfer(1, 4'h8, KEY, rd);
        chk("irq_clr", {31'd0, irq_o}, 32'd0);
        xfer(0, 4'hC, 32'h0, rd);
        chk("kick_to_run", {30'd0, rd[31:30]}, 32'd1);
        k = 0;
        while (!irq_o && k < 30) begin step(); k++; end
        k = 0;
        while (!rst_req_o && k < 30) begin step(); k++; end
        chk("warn_to_fire", k, 32'd7);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 99);
            if (op < 25) idle($urandom_range(1, 6));
            else if (op < 40) xfer(1, 4'h4, 32'($urandom_range(0, 12)), rd);
            else if (op < 52) xfer(1, 4'h0, 32'($urandom_range(0, 3)), rd);
            else if (op < 72) xfer(1, 4'h8, KEY, rd);
            else if (op < 75) xfer(1, 4'h8, $urandom, rd);
            else if (op < 96) xfer(0, 4'($urandom), 32'h0, rd);
            else begin
                // Reset arriving with an access pending: no ack may follow.
                wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1'($urandom);
                wb_adr_i = 4'($urandom); wb_dat_i = $urandom;
                wb_rst_i = 1; step();
                wb_rst_i = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
                step();
            end
        end
        idle(3);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
